// File: rtl/eq_arbiter_if.sv
// eq_arbiter_if: requester, comparator and response signals of the equality-compare arbiter
interface eq_arbiter_if #(
   parameter int NUM = 4,
   parameter int W   = 16
);
   logic [NUM*2*W-1:0] req_data;
   logic [NUM-1:0]     req_valid;
   logic [NUM-1:0]     req_ready;
   logic [2*W-1:0]     cmp_data;
   logic               cmp_valid;
   logic               cmp_ready;
   logic               res_data;
   logic               res_valid;
   logic               res_ready;
   logic [NUM-1:0]     resp_data;
   logic [NUM-1:0]     resp_valid;
   logic [NUM-1:0]     resp_ready;
   logic               busy;
   logic               timeout_err;
   modport slave (
      input  req_data, req_valid, cmp_ready, res_data, res_valid, resp_ready,
      output req_ready, cmp_data, cmp_valid, res_ready, resp_data, resp_valid, busy, timeout_err
   );
   modport master (
      output req_data, req_valid, cmp_ready, res_data, res_valid, resp_ready,
      input  req_ready, cmp_data, cmp_valid, res_ready, resp_data, resp_valid, busy, timeout_err
   );
endinterface

// File: rtl/eq_arbiter.sv
// eq_arbiter: round-robin sharing of one equality comparator among NUM requesters; define EQ_ARB_TIMEOUT_EN to abort stalled ISSUE after TIMEOUT cycles
module eq_arbiter #(
   parameter int NUM     = 4,
   parameter int W       = 16,
   parameter int TIMEOUT = 255
) (
   input logic         clk,
   input logic         rst,
   eq_arbiter_if.slave bus
);
   localparam int GW = $clog2(NUM);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t         r_state;
   logic [GW-1:0]  r_ptr, r_g, w_g;
   logic [2*W-1:0] r_ops, w_ops;
   logic           r_cmp_valid, r_cmp_done, r_res_done, r_res, r_to;
   logic [NUM-1:0] r_resp_valid, r_resp_data;
   logic           w_any, w_cmp_hs, w_res_hs, w_cd, w_rd, w_to;
   if (NUM < 2 || NUM > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
      $error("eq_arbiter: parameter out of range");
   end
   // Round-robin pick: first valid requester at or after ptr, and its operand pair
   always_comb begin
      logic [GW-1:0] idx;
      idx   = '0;
      w_g   = '0;
      w_ops = '0;
      for (int k = NUM - 1; k >= 0; k--) begin
         idx = GW'((int'(r_ptr) + k) % NUM);
         if (bus.req_valid[idx]) w_g = idx;
      end
      for (int i = 0; i < NUM; i++) if (w_g == GW'(i)) w_ops = bus.req_data[i*2*W +: 2*W];
   end
   assign w_any    = |bus.req_valid;
   assign w_cmp_hs = r_cmp_valid & bus.cmp_ready;
   assign w_res_hs = bus.res_ready & bus.res_valid;
   assign w_cd     = r_cmp_done | w_cmp_hs;
   assign w_rd     = r_res_done | w_res_hs;
`ifdef EQ_ARB_TIMEOUT_EN
   logic [7:0] r_cnt;
   // Count ISSUE cycles; the count restarts whenever ISSUE is entered
   always_ff @(posedge clk)
      if (!rst || r_state != ISSUE) r_cnt <= '0;
      else r_cnt <= r_cnt + 8'd1;
   assign w_to = r_state == ISSUE && r_cnt == 8'(TIMEOUT - 1);
`else
   assign w_to = 1'b0;
`endif
   // Transaction FSM: grant in IDLE, two independent handshakes in ISSUE, hold the response in RESP
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_ptr        <= '0;
         r_g          <= '0;
         r_ops        <= '0;
         r_cmp_valid  <= 1'b0;
         r_cmp_done   <= 1'b0;
         r_res_done   <= 1'b0;
         r_res        <= 1'b0;
         r_to         <= 1'b0;
         r_resp_valid <= '0;
         r_resp_data  <= '0;
      end else begin
         r_to <= 1'b0;
         case (r_state)
            IDLE: if (w_any) begin
               r_g         <= w_g;
               r_ops       <= w_ops;
               r_cmp_valid <= 1'b1;
               r_cmp_done  <= 1'b0;
               r_res_done  <= 1'b0;
               r_state     <= ISSUE;
            end
            ISSUE: begin
               r_cmp_done <= w_cd;
               r_res_done <= w_rd;
               if (w_cmp_hs) r_cmp_valid <= 1'b0;
               if (w_res_hs) r_res <= bus.res_data;
               if (w_cd && w_rd) begin
                  r_state      <= RESP;
                  r_resp_valid <= NUM'(1) << r_g;
                  r_resp_data  <= (w_res_hs ? bus.res_data : r_res) ? NUM'(1) << r_g : '0;
               end else if (w_to) begin
                  r_state      <= RESP;
                  r_cmp_valid  <= 1'b0;
                  r_to         <= 1'b1;
                  r_resp_valid <= NUM'(1) << r_g;
                  r_resp_data  <= '0;
               end
            end
            RESP: if (bus.resp_ready[r_g]) begin
               r_state      <= IDLE;
               r_resp_valid <= '0;
               r_resp_data  <= '0;
               r_ptr        <= (r_g == GW'(NUM - 1)) ? '0 : r_g + 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.req_ready   = (r_state == IDLE && rst && w_any) ? NUM'(1) << w_g : '0;
   assign bus.cmp_data    = r_ops;
   assign bus.cmp_valid   = r_cmp_valid;
   assign bus.res_ready   = r_state == ISSUE && !r_res_done;
   assign bus.resp_valid  = r_resp_valid;
   assign bus.resp_data   = r_resp_data;
   assign bus.busy        = r_state != IDLE;
   assign bus.timeout_err = r_to;
endmodule

// File: tb/tb_eq_arbiter.sv
// tb_eq_arbiter: vector table plus corner sequences for eq_arbiter, responses checked through a scoreboard queue
module tb_eq_arbiter;
   typedef struct {
      logic [3:0]   mask;
      logic [127:0] data;
      int           g;
      logic         res;
   } vec_t;
   logic       clk, rst;
   logic       pipe_mode, stuck, p_valid, p_data, w_eq;
   int         lat, p_cnt;
   int         n_cmp, n_err;
   logic [2:0] sb[$];
   logic [2:0] m_e;
   logic [3:0] m_oh;
   vec_t       tbl[8];
   eq_arbiter_if #(.NUM(4), .W(16)) bus ();
   eq_arbiter #(.NUM(4), .W(16), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   assign w_eq          = bus.cmp_data[15:0] == bus.cmp_data[31:16];
   assign bus.cmp_ready = !stuck;
   assign bus.res_valid = pipe_mode ? p_valid : bus.cmp_valid && !stuck;
   assign bus.res_data  = pipe_mode ? p_data : w_eq;
   always @(posedge clk) begin
      if (!rst) begin
         p_valid <= 1'b0;
         p_cnt   <= 0;
      end else begin
         if (pipe_mode && bus.cmp_valid && bus.cmp_ready) begin
            p_cnt  <= lat;
            p_data <= w_eq;
         end else if (p_cnt > 1) p_cnt <= p_cnt - 1;
         else if (p_cnt == 1) begin
            p_valid <= 1'b1;
            p_cnt   <= 0;
         end
         if (p_valid && bus.res_ready) p_valid <= 1'b0;
      end
   end
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [47:0] outs();
      return {bus.req_ready, bus.cmp_data, bus.cmp_valid, bus.res_ready,
              bus.resp_data, bus.resp_valid, bus.busy, bus.timeout_err};
   endfunction
   always @(negedge clk) begin
      #2;
      if (rst && |(bus.resp_valid & bus.resp_ready)) begin
         if (sb.size() == 0) chk("resp_unexpected", 64'(bus.resp_valid), 64'd0);
         else begin
            m_e  = sb.pop_front();
            m_oh = 4'(1) << m_e[2:1];
            chk("sb_resp", {bus.resp_valid, bus.resp_data}, {m_oh, m_e[0] ? m_oh : 4'b0});
         end
      end
   end
   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask
   task automatic apply(input vec_t v);
      logic [31:0] ops;
      logic [3:0]  oh;
      int c;
      oh = 4'(1) << v.g;
      ops = v.data[v.g*32 +: 32];
      @(negedge clk);
      bus.req_valid = v.mask;
      bus.req_data  = v.data;
      #1;
      c = 0;
      while (bus.req_ready == 4'b0 && c < 10) begin
         @(negedge clk);
         #1;
         c++;
      end
      chk("grant", 64'(bus.req_ready), 64'(oh));
      sb.push_back({2'(v.g), v.res});
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      chk("issue", {bus.cmp_data, bus.cmp_valid, bus.res_ready, bus.busy}, {ops, 3'b111});
      @(negedge clk);
      #1;
      chk("resp", {bus.resp_valid, bus.resp_data, bus.cmp_valid, bus.busy}, {oh, v.res ? oh : 4'b0, 2'b01});
      @(negedge clk);
      #1;
      chk("idle", {bus.busy, bus.resp_valid}, 64'd0);
   endtask
   initial begin
      int c;
      n_cmp = 0;
      n_err = 0;
      tbl[0] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h1234_1234}, 0, 1'b1};
      tbl[1] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h00FE_00FF}, 0, 1'b0};
      tbl[2] = '{4'b1010, {32'h0001_0002, 32'h0, 32'hABCD_ABCD, 32'h0}, 1, 1'b1};
      tbl[3] = '{4'b1010, {32'h0001_0002, 32'h0, 32'hABCD_ABCD, 32'h0}, 3, 1'b0};
      tbl[4] = '{4'b0110, {32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0}, 1, 1'b1};
      tbl[5] = '{4'b0110, {32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0}, 2, 1'b0};
      tbl[6] = '{4'b1111, {32'h0000_0000, 32'h3333_3334, 32'h2222_2222, 32'h1111_1111}, 3, 1'b1};
      tbl[7] = '{4'b1100, {32'h5A5A_5A5A, 32'hFFFF_7FFF, 32'h0, 32'h0}, 2, 1'b0};
      bus.req_valid  = '0;
      bus.req_data   = '0;
      bus.resp_ready = '1;
      pipe_mode = 1'b0;
      stuck     = 1'b0;
      lat       = 5;
      rst       = 1'b0;
      repeat (2) @(negedge clk);
      bus.req_valid = '1;
      bus.req_data  = {4{32'hAAAA_AAAA}};
      @(negedge clk);
      #1;
      chk("reset_outputs", 64'(outs()), 64'd0);
      @(negedge clk);
      bus.req_valid = '0;
      rst = 1'b1;
      #1;
      chk("idle_after_reset", 64'(outs()), 64'd0);
      for (int i = 0; i < 8; i++) apply(tbl[i]);
      reset_dut();
      bus.req_data = {32'h0003_0004, 32'h0002_0002, 32'h0001_0000, 32'h0000_0000};
      for (int k = 0; k < 5; k++) sb.push_back({2'(k % 4), 1'(k % 2 == 0)});
      @(negedge clk);
      bus.req_valid = '1;
      for (int k = 0; k < 15; k++) begin
         #1;
         chk("rr_grant", 64'(bus.req_ready), 64'((k % 3 == 0) ? 4'(1) << ((k / 3) % 4) : 4'b0));
         @(negedge clk);
      end
      bus.req_valid = '0;
      pipe_mode = 1'b1;
      @(negedge clk);
      bus.req_valid = 4'b0010;
      bus.req_data  = {32'h0, 32'h0, 32'h00FE_00FF, 32'h0};
      #1;
      chk("pipe_grant", 64'(bus.req_ready), 64'b0010);
      sb.push_back(3'b010);
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      chk("pipe_issue", {bus.cmp_valid, bus.res_ready}, 64'b11);
      @(negedge clk);
      #1;
      chk("pipe_after_hs", {bus.cmp_valid, bus.res_ready, bus.busy}, 64'b011);
      c = 0;
      while (bus.resp_valid == 4'b0 && c < 20) begin
         @(negedge clk);
         #1;
         c++;
      end
      chk("pipe_resp", {bus.resp_valid, bus.resp_data, bus.cmp_valid}, {4'b0010, 4'b0000, 1'b0});
      pipe_mode = 1'b0;
      @(negedge clk);
      bus.resp_ready = '0;
      bus.req_valid  = 4'b0100;
      bus.req_data   = {32'h0, 32'h4321_4321, 64'h0};
      #1;
      chk("hold_grant", 64'(bus.req_ready), 64'b0100);
      sb.push_back(3'b101);
      @(negedge clk);
      bus.req_valid = 4'b1011;
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("hold", {bus.resp_valid, bus.resp_data, bus.req_ready}, 64'b0100_0100_0000);
         @(negedge clk);
      end
      bus.req_valid  = '0;
      bus.resp_ready = '1;
      pipe_mode = 1'b1;
      @(negedge clk);
      bus.req_valid = 4'b1000;
      bus.req_data  = {32'h9999_9999, 96'h0};
      #1;
      chk("rst_grant", 64'(bus.req_ready), 64'b1000);
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      chk("rst_issue", 64'(bus.busy), 64'd1);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_mid_outputs", 64'(outs()), 64'd0);
      rst = 1'b1;
      pipe_mode = 1'b0;
      apply('{4'b1111, {32'h0, 32'h0, 32'h0, 32'h7777_7777}, 0, 1'b1});
      stuck = 1'b1;
      @(negedge clk);
      bus.req_valid = 4'b0001;
      bus.req_data  = '0;
      #1;
      chk("to_grant", 64'(bus.req_ready), 64'b0001);
`ifdef EQ_ARB_TIMEOUT_EN
      sb.push_back(3'b000);
`endif
      @(negedge clk);
      bus.req_valid = '0;
      for (int k = 1; k <= 8; k++) begin
         #1;
         chk("to_wait", {bus.cmp_valid, bus.busy, bus.timeout_err}, 64'b110);
         @(negedge clk);
      end
`ifdef EQ_ARB_TIMEOUT_EN
      #1;
      chk("to_pulse", {bus.timeout_err, bus.resp_valid, bus.resp_data, bus.cmp_valid}, {1'b1, 4'b0001, 4'b0000, 1'b0});
      @(negedge clk);
      #1;
      chk("to_clear", {bus.timeout_err, bus.busy}, 64'b00);
      stuck = 1'b0;
`else
      repeat (20) @(negedge clk);
      #1;
      chk("no_timeout", {bus.cmp_valid, bus.busy, bus.timeout_err, bus.resp_valid}, {3'b110, 4'b0000});
      reset_dut();
      stuck = 1'b0;
      #1;
      chk("stuck_reset", 64'(outs()), 64'd0);
`endif
      repeat (2) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
